// File: rtl/flag_seq_pkg.sv
// flag_seq_pkg: shared state/pending enums, default visible width and selector wrap helpers
// for flag_sequencer.
package flag_seq_pkg;

    typedef enum logic {HOLD, WIPE} state_t;
    typedef enum logic [1:0] {NONE, NEXT, PREV} pend_t;

    localparam int H_ACTIVE_DEF = 640;

    function automatic int wrap_inc(input int sel, input int num_flags);
        return (sel >= num_flags - 1) ? 0 : sel + 1;
    endfunction

    function automatic int wrap_dec(input int sel, input int num_flags);
        return (sel == 0) ? num_flags - 1 : sel - 1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser for an asynchronous button followed by a
// single-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    logic [2:0] r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sh <= '0;
        else        r_sh <= {r_sh[1:0], i_btn};
    end

    assign o_pulse = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/flag_sequencer.sv
// flag_sequencer: frame-synchronous flag slideshow (hold timer, next/prev buttons).
// Define FLAG_SEQ_WIPE_EN for the left-to-right wipe; otherwise flags switch directly.
module flag_sequencer
    import flag_seq_pkg::*;
#(
    parameter int NUM_FLAGS   = 86,
    parameter int SEL_W       = 7,
    parameter int HOLD_FRAMES = 180,
    parameter int WIPE_STEP   = 16,
    parameter int H_ACTIVE    = H_ACTIVE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    input  logic [9:0]       pix_x,
    input  logic [5:0]       color_cur,
    input  logic [5:0]       color_nxt,
    output logic [SEL_W-1:0] sel_cur,
    output logic [SEL_W-1:0] sel_nxt,
    output logic [5:0]       color,
    output logic             busy
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic             w_pn, w_pp, w_go, w_clr;
    pend_t            r_pend, w_pend;
    logic [SEL_W-1:0] r_sel_cur, w_sel_cur, w_tgt;
    logic [HW-1:0]    r_hold, w_hold;
    logic [5:0]       r_color;

    btn_sync_edge u_next (.clk(clk), .rst_n(rst_n), .i_btn(btn_next), .o_pulse(w_pn));
    btn_sync_edge u_prev (.clk(clk), .rst_n(rst_n), .i_btn(btn_prev), .o_pulse(w_pp));

    assign w_go  = (r_pend != NONE) || (auto_en && r_hold == HW'(HOLD_FRAMES - 1));
    assign w_tgt = (r_pend == PREV) ? SEL_W'(wrap_dec(int'(r_sel_cur), NUM_FLAGS))
                                    : SEL_W'(wrap_inc(int'(r_sel_cur), NUM_FLAGS));

    // A fresh edge wins over the consumption of an older request in the same cycle.
    always_comb begin
        w_pend = r_pend;
        if (w_pn && !w_pp)      w_pend = NEXT;
        else if (w_pp && !w_pn) w_pend = PREV;
        else if (w_clr)         w_pend = NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_cur <= '0;
            r_hold    <= '0;
            r_pend    <= NONE;
        end else begin
            r_sel_cur <= w_sel_cur;
            r_hold    <= w_hold;
            r_pend    <= w_pend;
        end
    end

`ifdef FLAG_SEQ_WIPE_EN
    state_t           r_state, w_state;
    logic [SEL_W-1:0] r_sel_nxt, w_sel_nxt;
    logic [9:0]       r_wipe_x, w_wipe_x;
    logic [10:0]      w_sum;

    // Widened by one bit so the edge cannot wrap past H_ACTIVE.
    assign w_sum = {1'b0, r_wipe_x} + 11'(WIPE_STEP);

    always_comb begin
        w_state   = r_state;
        w_sel_cur = r_sel_cur;
        w_sel_nxt = r_sel_nxt;
        w_wipe_x  = r_wipe_x;
        w_hold    = r_hold;
        w_clr     = 1'b0;
        if (frame_start && r_state == HOLD) begin
            if (w_go) begin
                w_clr     = 1'b1;
                w_sel_nxt = w_tgt;
                w_hold    = '0;
                w_wipe_x  = '0;
                w_state   = WIPE;
            end else begin
                w_hold = auto_en ? r_hold + 1'b1 : '0;
            end
        end else if (frame_start) begin
            w_wipe_x = w_sum[9:0];
            if (w_sum >= 11'(H_ACTIVE)) begin
                w_sel_cur = r_sel_nxt;
                w_wipe_x  = '0;
                w_state   = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HOLD;
            r_sel_nxt <= '0;
            r_wipe_x  <= '0;
            r_color   <= '0;
        end else begin
            r_state   <= w_state;
            r_sel_nxt <= w_sel_nxt;
            r_wipe_x  <= w_wipe_x;
            r_color   <= (r_state == WIPE && pix_x < r_wipe_x) ? color_nxt : color_cur;
        end
    end

    assign sel_nxt = r_sel_nxt;
    assign busy    = (r_state == WIPE);
`else
    logic w_unused;
    assign w_unused = ^{pix_x, color_nxt};

    always_comb begin
        w_sel_cur = r_sel_cur;
        w_hold    = r_hold;
        w_clr     = 1'b0;
        if (frame_start) begin
            if (w_go) begin
                w_clr     = 1'b1;
                w_sel_cur = w_tgt;
                w_hold    = '0;
            end else begin
                w_hold = auto_en ? r_hold + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_color <= '0;
        else        r_color <= color_cur;
    end

    assign sel_nxt = r_sel_cur;
    assign busy    = 1'b0;
`endif

    assign sel_cur = r_sel_cur;
    assign color   = r_color;
endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: directed, table-driven and randomized checks of flag_sequencer
// against a behavioural slideshow model; works with FLAG_SEQ_WIPE_EN on or off.
module tb_flag_sequencer;
`ifdef FLAG_SEQ_WIPE_EN
    localparam bit WIPE_ON = 1'b1;
`else
    localparam bit WIPE_ON = 1'b0;
`endif
    localparam int NF = 86;
    localparam int HF = 3;
    localparam int ST = 16;
    localparam int HA = 640;
    localparam int WF = WIPE_ON ? 40 : 0;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       frame_start = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0;
    logic [9:0] pix_x = '0;
    logic [5:0] color_cur = '0, color_nxt = '0;
    logic [6:0] sel_cur, sel_nxt;
    logic [5:0] color;
    logic       busy;
    bit         rnd = 1'b0;
    int         n_chk = 0, n_fail = 0;

    flag_sequencer #(.NUM_FLAGS(NF), .SEL_W(7), .HOLD_FRAMES(HF), .WIPE_STEP(ST), .H_ACTIVE(HA)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .btn_next(btn_next),
        .btn_prev(btn_prev), .auto_en(auto_en), .pix_x(pix_x), .color_cur(color_cur),
        .color_nxt(color_nxt), .sel_cur(sel_cur), .sel_nxt(sel_nxt), .color(color), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: shown flag, incoming flag, wipe edge, hold frames, request direction.
    int   m_cur, m_nxt, m_edge, m_hold, m_req, m_dir;
    bit   m_wip, m_used, m_en, m_ep;
    bit   n1, n2, n3, p1, p2, p3;
    logic [5:0] m_col;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = 0; m_nxt = 0; m_edge = 0; m_hold = 0; m_req = 0; m_wip = 0; m_col = '0;
            n1 = 0; n2 = 0; n3 = 0; p1 = 0; p2 = 0; p3 = 0;
        end else begin
            m_en = n2 && !n3;
            m_ep = p2 && !p3;
            n3 = n2; n2 = n1; n1 = btn_next;
            p3 = p2; p2 = p1; p1 = btn_prev;
            m_col  = (m_wip && int'(pix_x) < m_edge) ? color_nxt : color_cur;
            m_used = 0;
            if (frame_start) begin
                if (!m_wip) begin
                    if (m_req != 0 || (auto_en && m_hold == HF - 1)) begin
                        m_dir  = (m_req != 0) ? m_req : 1;
                        m_used = 1;
                        m_hold = 0;
                        if (WIPE_ON) begin
                            m_nxt = (m_cur + m_dir + NF) % NF; m_wip = 1; m_edge = 0;
                        end else begin
                            m_cur = (m_cur + m_dir + NF) % NF;
                        end
                    end else begin
                        m_hold = auto_en ? m_hold + 1 : 0;
                    end
                end else begin
                    m_edge += ST;
                    if (m_edge >= HA) begin
                        m_cur = m_nxt; m_wip = 0; m_edge = 0;
                    end
                end
            end
            if (m_en != m_ep) m_req = m_en ? 1 : -1;
            else if (m_used)  m_req = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_sel_cur", sel_cur, m_cur);
            chk("mdl_sel_nxt", sel_nxt, m_wip ? m_nxt : m_cur);
            chk("mdl_busy", busy, m_wip);
            chk("mdl_color", color, m_col);
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (rnd) begin
            color_cur = 6'($urandom);
            color_nxt = 6'($urandom);
            pix_x     = 10'($urandom);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n; btn_prev = p;
        repeat (3) cyc();
        btn_next = 1'b0; btn_prev = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic go(input logic n, input logic p);
        press(n, p);
        frame();
        repeat (WF) frame();
    endtask

    typedef struct {
        logic [9:0] px;
        logic [5:0] cc;
        logic [5:0] cn;
        logic [5:0] exp;
    } vec_t;
    vec_t tv[4];

    initial begin
        tv[0] = '{10'd319, 6'h15, 6'h2a, WIPE_ON ? 6'h2a : 6'h15};
        tv[1] = '{10'd320, 6'h15, 6'h2a, 6'h15};
        tv[2] = '{10'd0,   6'h07, 6'h38, WIPE_ON ? 6'h38 : 6'h07};
        tv[3] = '{10'd639, 6'h07, 6'h38, 6'h07};

        color_cur = 6'h3f; color_nxt = 6'h3f;
        repeat (3) cyc();
        chk("rst_sel_cur", sel_cur, 0);
        chk("rst_sel_nxt", sel_nxt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_color", color, 0);
        rst_n = 1'b1;
        rnd   = 1'b1;

        repeat (10) frame();
        chk("idle_sel_cur", sel_cur, 0);
        chk("idle_busy", busy, 0);
        rnd = 1'b0;
        color_cur = 6'h2d;
        cyc();
        chk("lat_color_a", color, 6'h2d);
        color_cur = 6'h12;
        chk("lat_color_hold", color, 6'h2d);
        cyc();
        chk("lat_color_b", color, 6'h12);
        rnd = 1'b1;

        press(1'b1, 1'b0);
        frame();
        chk("next_busy", busy, WIPE_ON);
        chk("next_sel_nxt", sel_nxt, 1);
        chk("next_sel_cur", sel_cur, WIPE_ON ? 0 : 1);
        repeat (WIPE_ON ? 20 : 0) frame();
        rnd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_x = tv[i].px; color_cur = tv[i].cc; color_nxt = tv[i].cn;
            cyc();
            chk($sformatf("mux_px%0d", tv[i].px), color, tv[i].exp);
        end
        rnd = 1'b1;
        repeat (WIPE_ON ? 19 : 0) frame();
        chk("wipe39_busy", busy, WIPE_ON);
        repeat (WIPE_ON ? 1 : 0) frame();
        chk("wipe_done_busy", busy, 0);
        chk("wipe_done_sel_cur", sel_cur, 1);

        go(1'b0, 1'b1);
        chk("back_to_0", sel_cur, 0);
        press(1'b0, 1'b1);
        frame();
        chk("prev_wrap_sel_nxt", sel_nxt, 85);
        repeat (WF) frame();
        chk("prev_wrap_sel_cur", sel_cur, 85);
        press(1'b1, 1'b0);
        frame();
        chk("next_wrap_sel_nxt", sel_nxt, 0);
        repeat (WF) frame();
        chk("next_wrap_sel_cur", sel_cur, 0);

        auto_en = 1'b1;
        frame();
        chk("auto_f1_busy", busy, 0);
        chk("auto_f1_sel_nxt", sel_nxt, 0);
        frame();
        chk("auto_f2_sel_nxt", sel_nxt, 0);
        frame();
        chk("auto_f3_sel_nxt", sel_nxt, 1);
        chk("auto_f3_busy", busy, WIPE_ON);
        auto_en = 1'b0;
        repeat (WF) frame();
        chk("auto_sel_cur", sel_cur, 1);

        if (WIPE_ON) begin
            press(1'b1, 1'b0);
            frame();
            repeat (5) frame();
            press(1'b1, 1'b0);
            repeat (35) frame();
            chk("queued_first_done", sel_cur, 2);
            chk("queued_first_busy", busy, 0);
            frame();
            chk("queued_second_busy", busy, 1);
            chk("queued_second_nxt", sel_nxt, 3);
            repeat (40) frame();
        end else begin
            go(1'b1, 1'b0);
            go(1'b1, 1'b0);
        end
        chk("queued_sel_cur", sel_cur, 3);

        press(1'b1, 1'b1);
        frame();
        chk("both_busy", busy, 0);
        chk("both_sel_cur", sel_cur, 3);
        chk("both_sel_nxt", sel_nxt, 3);

        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
            repeat ($urandom_range(2, 9)) begin
                if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
                if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
                cyc();
            end
        end
        btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
        repeat (4) cyc();

        press(1'b1, 1'b0);
        frame();
        repeat (10) frame();
        chk("pre_rst_busy", busy, WIPE_ON);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel_cur", sel_cur, 0);
        chk("async_rst_sel_nxt", sel_nxt, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_color", color, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) frame();
        chk("post_rst_sel_cur", sel_cur, 0);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/flag_sequencer.md
# flag_sequencer

Frame-synchronous slideshow controller that sits between the VGA timing generator and two flag-index lookups. It chooses which flag is shown and advances automatically after a hold time or on button request. Changes between flags use a left-to-right wipe. It drives the selectors of a "current" and a "next" flag-index instance and muxes their colours into a registered pixel colour.

## Interface
Parameters:
- NUM_FLAGS, 86: number of selectable flags; valid selectors are 0..NUM_FLAGS-1.
- SEL_W, 7: selector width; must satisfy 2^SEL_W >= NUM_FLAGS.
- HOLD_FRAMES, 180: frames a flag is held before auto-advance.
- WIPE_STEP, 16: wipe edge advance per frame, in pixels.
- H_ACTIVE, 640: visible width; the wipe completes when the edge reaches this value.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse, first cycle of vertical blanking.
- btn_next  in  1  asynchronous button; a rising edge requests the next flag.
- btn_prev  in  1  asynchronous button; a rising edge requests the previous flag.
- auto_en  in  1  level input; 1 enables the hold-timer auto-advance.
- pix_x  in  10  current pixel column.
- color_cur  in  6  colour from the flag-index instance driven by sel_cur.
- color_nxt  in  6  colour from the flag-index instance driven by sel_nxt.
- sel_cur  out  SEL_W  selector of the flag currently displayed.
- sel_nxt  out  SEL_W  selector of the incoming flag.
- color  out  6  registered output pixel colour.
- busy  out  1  high while in WIPE.

## Operation
- Reset values: state HOLD, sel_cur=0, sel_nxt=0, wipe_x=0, hold_cnt=0, pending=NONE, color=0, busy=0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge sets pending to NEXT or PREV; a later edge overwrites an earlier one.
  - Both edges in the same cycle: the pending value is unchanged.
- All state, selector and counter updates happen only in the cycle where frame_start=1.
- State HOLD, on frame_start:
  - If pending is not NONE: target = sel_cur±1 with wrap (NUM_FLAGS-1 -> 0 going up, 0 -> NUM_FLAGS-1 going down). Then sel_nxt=target, pending=NONE, hold_cnt=0, wipe_x=0, go to WIPE.
  - Else if auto_en=1 and hold_cnt==HOLD_FRAMES-1: same transition with target = sel_cur+1 with wrap.
  - Else: hold_cnt increments while auto_en=1; it is cleared to 0 when auto_en=0.
- State WIPE, on frame_start:
  - wipe_x += WIPE_STEP.
  - If the new wipe_x >= H_ACTIVE: sel_cur=sel_nxt, wipe_x=0, go to HOLD.
  - Button requests arriving during WIPE stay in pending and are serviced on the first frame_start after returning to HOLD.
- Pixel mux, every cycle: color <= (state==WIPE && pix_x < wipe_x) ? color_nxt : color_cur.
- In HOLD, sel_nxt is held equal to sel_cur.
- wipe_x is 10 bits wide; the saturation compare is made at 11 bits so the sum cannot wrap.

## Timing
- color has 1-cycle latency from pix_x / color_cur / color_nxt.
- Selector changes take effect the cycle after frame_start, which is during blanking, so there is no visible tearing.
- Button to wipe start: 2 cycles of synchroniser plus the wait for the next frame_start.
- Wipe duration: ceil(H_ACTIVE/WIPE_STEP) frames, which is 40 frames at the defaults.
- busy rises and falls the cycle after the frame_start that causes the transition.
- Reset asserted mid-wipe forces all reset values immediately (asynchronous); pending requests are lost.

## Configuration
- FLAG_SEQ_WIPE_EN defined: wipe behaviour as described above.
- FLAG_SEQ_WIPE_EN undefined:
  - WIPE state and wipe_x are removed; busy is tied to 0.
  - A transition sets sel_cur=target directly on frame_start.
  - color <= color_cur.
  - sel_nxt mirrors sel_cur.

## Structure
- flag_seq_pkg holds:
  - the state enum (HOLD, WIPE);
  - the pending enum (NONE, NEXT, PREV);
  - the default H_ACTIVE constant;
  - a wrap-increment/decrement function taking (sel, NUM_FLAGS).
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, instantiated once per button.

## Test plan
- Reset, then NUM_FLAGS=86, auto_en=0, no buttons, 10 frames -> sel_cur=0, busy=0, color tracks color_cur with 1-cycle latency.
- Pulse btn_next -> WIPE starts at the next frame_start with sel_nxt=1. After 40 frames sel_cur=1 and busy=0. Mid-wipe, with wipe_x=320: pix_x=319 shows color_nxt and pix_x=320 shows color_cur.
- sel_cur=0, pulse btn_prev -> sel_nxt=85. sel_cur=85, pulse btn_next -> sel_nxt=0.
- auto_en=1, HOLD_FRAMES=3 -> a wipe starts on the 3rd frame_start after entering HOLD and advances by +1.
- btn_next pressed during WIPE -> a second wipe starts on the first frame_start after completion. btn_next and btn_prev rising in the same cycle -> no transition.
- Define nothing (macro off), pulse btn_next -> sel_cur increments on the next frame_start and busy stays 0. Assert rst_n mid-wipe (macro on) -> all outputs return to reset values immediately.
